serial_onehot_rx: RTL



---
 rtl/serial_onehot_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_onehot_rx.sv
// Oversampled scl/sda frame receiver: accepted DATA_W-bit words drive a one-hot OUT_W-line output.
// Build option: define SERIAL_ONEHOT_RX_PARITY_EN to require an even-parity bit after the payload.
module serial_onehot_rx #(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    localparam int OUT_W      = 1 << DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    input  logic              sda,
    output logic [OUT_W-1:0]  outhigh,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

`ifdef SERIAL_ONEHOT_RX_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 2);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   pend_q, pend_d;
    logic                   pend_bit_q, pend_bit_d;
    logic [OUT_W-1:0]       outhigh_q, outhigh_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;

    logic                   scl_s, sda_s;
    logic                   start_evt, stop_evt, scl_rise, scl_fall;
    logic [DATA_W-1:0]      payload;
    logic                   check_ok;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign start_evt = scl_prev_q & scl_s & sda_prev_q & ~sda_s;
    assign stop_evt  = scl_prev_q & scl_s & ~sda_prev_q & sda_s;
    assign scl_rise  = ~scl_prev_q & scl_s;
    assign scl_fall  = scl_prev_q & ~scl_s;

`ifdef SERIAL_ONEHOT_RX_PARITY_EN
    assign payload  = shift_q[FRAME_LEN-1:1];
    assign check_ok = ~^shift_q;
`else
    assign payload  = shift_q;
    assign check_ok = 1'b1;
`endif

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // A bit sampled on scl rise is only committed on the following scl fall, so the
    // clock pulse that carries a stop condition never lands in the frame.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        pend_d     = pend_q;
        pend_bit_d = pend_bit_q;
        outhigh_d  = outhigh_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    state_d = RECV;
                    shift_d = '0;
                    count_d = '0;
                    pend_d  = 1'b0;
                end
            end
            RECV: begin
                if (start_evt) begin
                    shift_d = '0;
                    count_d = '0;
                    pend_d  = 1'b0;
                end else if (stop_evt) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    if (count_q == CNT_W'(FRAME_LEN) && check_ok) begin
                        data_d    = payload;
                        outhigh_d = OUT_W'(1) << payload;
                        valid_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (scl_rise) begin
                    pend_d     = 1'b1;
                    pend_bit_d = sda_s;
                end else if (scl_fall && pend_q) begin
                    pend_d  = 1'b0;
                    shift_d = (shift_q << 1) | FRAME_LEN'(pend_bit_q);
                    if (count_q != CNT_W'(FRAME_LEN + 1)) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RECV);
    end

    // Synchroniser and edge-history flops reset high so reset looks like an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            pend_bit_q <= 1'b0;
            outhigh_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            pend_bit_q <= pend_bit_d;
            outhigh_q  <= outhigh_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign outhigh   = outhigh_q;
    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
